// File: rtl/binary_search_ctrl_pkg.sv
// Shared types for the binary-search controller: FSM states, comparator flag
// bundle and the one-hot legality check used by design and bench alike.
package search_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    DONE  = 2'd2
  } search_state_t;

  typedef struct packed {
    logic equal;
    logic lower;
    logic greater;
  } cmp_flags_t;

  // Exactly one comparator flag may be set for a probe to be trusted.
  function automatic logic one_hot(input cmp_flags_t f);
    return (f == 3'b100) || (f == 3'b010) || (f == 3'b001);
  endfunction

endpackage

// File: rtl/binary_search_ctrl_if.sv
// Bundle between the search controller and its environment: start/status on
// one side, guess out to the comparator and its result flags back.
interface binary_search_ctrl_if #(parameter int WIDTH = 4);
  localparam int PW = $clog2(WIDTH + 2);

  logic             start;
  logic [WIDTH-1:0] guess;
  logic             equal;
  logic             lower;
  logic             greater;
  logic             busy;
  logic             done;
  logic             found;
  logic             err;
  logic [WIDTH-1:0] result;
  logic [PW-1:0]    probes;

  modport master (
    input  start, equal, lower, greater,
    output guess, busy, done, found, err, result, probes
  );

  modport slave (
    output start, equal, lower, greater,
    input  guess, busy, done, found, err, result, probes
  );
endinterface

// File: rtl/comparator.sv
// Magnitude comparator: flags how operand a relates to operand b.
module comparator #(parameter int WIDTH = 4) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             equal,
  output logic             lower,
  output logic             greater
);
  assign equal   = (a == b);
  assign lower   = (a < b);
  assign greater = (a > b);
endmodule

// File: rtl/binary_search_ctrl.sv
// Successive-approximation controller: binary search over 0..2^WIDTH-1 driven
// by an external comparator, reporting the match, probe count and error.
module binary_search_ctrl
  import search_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  binary_search_ctrl_if.master bus
);
  localparam int PW = $clog2(WIDTH + 2);
  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};

  search_state_t    state_r, state_s;
  logic [WIDTH-1:0] lo_r, lo_s, hi_r, hi_s, guess_r, guess_s, result_r, result_s;
  logic [PW-1:0]    probes_r, probes_s;
  logic             busy_r, busy_s, done_r, done_s, found_r, found_s, err_r, err_s;
  logic [WIDTH:0]   lo_n_s, hi_n_s, mid_s;
  logic             cont_s, fin_s;
  cmp_flags_t       flags_s;

  assign bus.guess  = guess_r;
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.found  = found_r;
  assign bus.err    = err_r;
  assign bus.result = result_r;
  assign bus.probes = probes_r;

  // Next-state and next-output logic; bounds widened by one bit so lo+hi never wraps.
  always_comb begin
    flags_s  = '{equal: bus.equal, lower: bus.lower, greater: bus.greater};
    state_s  = state_r;
    lo_s     = lo_r;
    hi_s     = hi_r;
    guess_s  = guess_r;
    result_s = result_r;
    probes_s = probes_r;
    busy_s   = busy_r;
    done_s   = 1'b0;
    found_s  = found_r;
    err_s    = err_r;
    lo_n_s   = {1'b0, lo_r};
    hi_n_s   = {1'b0, hi_r};
    mid_s    = {(WIDTH + 1){1'b0}};
    cont_s   = 1'b0;
    fin_s    = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (bus.start) begin
          lo_s     = ZERO_VAL;
          hi_s     = MAX_VAL;
          guess_s  = MAX_VAL >> 1;
          probes_s = {PW{1'b0}};
          found_s  = 1'b0;
          err_s    = 1'b0;
          busy_s   = 1'b1;
          state_s  = PROBE;
        end else begin
          busy_s  = 1'b0;
          state_s = IDLE;
        end
      end
      PROBE: begin
        probes_s = probes_r + {{(PW - 1){1'b0}}, 1'b1};
        if (!one_hot(flags_s)) begin
          err_s = 1'b1;
          fin_s = 1'b1;
        end else if (flags_s.equal) begin
          found_s = 1'b1;
          fin_s   = 1'b1;
        end else if (flags_s.lower) begin
          if (guess_r == MAX_VAL) begin
            err_s = 1'b1;
            fin_s = 1'b1;
          end else begin
            lo_n_s = {1'b0, guess_r} + {{WIDTH{1'b0}}, 1'b1};
            cont_s = 1'b1;
          end
        end else begin
          if (guess_r == ZERO_VAL) begin
            err_s = 1'b1;
            fin_s = 1'b1;
          end else begin
            hi_n_s = {1'b0, guess_r} - {{WIDTH{1'b0}}, 1'b1};
            cont_s = 1'b1;
          end
        end
        // Inconsistent flags across probes can cross the bounds; treat that as exhaustion.
        if (cont_s) begin
          if (lo_n_s > hi_n_s) begin
            err_s = 1'b1;
            fin_s = 1'b1;
          end else begin
            mid_s   = lo_n_s + hi_n_s;
            lo_s    = lo_n_s[WIDTH-1:0];
            hi_s    = hi_n_s[WIDTH-1:0];
            guess_s = WIDTH'(mid_s >> 1);
          end
        end else begin
          mid_s = {(WIDTH + 1){1'b0}};
        end
        if (fin_s) begin
          result_s = guess_r;
          busy_s   = 1'b0;
          done_s   = 1'b1;
          state_s  = DONE;
        end else begin
          state_s = PROBE;
        end
      end
      default: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      lo_r     <= ZERO_VAL;
      hi_r     <= ZERO_VAL;
      guess_r  <= ZERO_VAL;
      result_r <= ZERO_VAL;
      probes_r <= {PW{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      found_r  <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      lo_r     <= lo_s;
      hi_r     <= hi_s;
      guess_r  <= guess_s;
      result_r <= result_s;
      probes_r <= probes_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      found_r  <= found_s;
      err_r    <= err_s;
    end
  end

endmodule

// File: tb/tb_binary_search_ctrl.sv
// Self-checking bench for binary_search_ctrl driving a real comparator; expected
// guess sequences come from an integer bisection model of the target.
module tb_binary_search_ctrl;
  import search_pkg::*;

  localparam int W = 4;
  localparam int MAXV = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [W-1:0] target;
  logic force_zero;
  logic c_eq, c_lt, c_gt;
  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];
  int order[16];

  always #5 clk = ~clk;

  binary_search_ctrl_if #(.WIDTH(W)) sif ();

  comparator #(.WIDTH(W)) u_cmp (
    .a(sif.guess), .b(target), .equal(c_eq), .lower(c_lt), .greater(c_gt)
  );

  assign sif.equal   = force_zero ? 1'b0 : c_eq;
  assign sif.lower   = force_zero ? 1'b0 : c_lt;
  assign sif.greater = force_zero ? 1'b0 : c_gt;

  binary_search_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(sif));

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Probe sequence of an ideal bisection over 0..MAXV for target t.
  function automatic void build_model(input int t);
    int lo, hi, g;
    exp_q.delete();
    lo = 0;
    hi = MAXV;
    while (lo <= hi) begin
      g = (lo + hi) / 2;
      exp_q.push_back(g);
      if (g == t) break;
      else if (g < t) lo = g + 1;
      else hi = g - 1;
    end
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_guess"},  32'(sif.guess), 0);
    check_val({tag, "_busy"},   32'(sif.busy), 0);
    check_val({tag, "_done"},   32'(sif.done), 0);
    check_val({tag, "_found"},  32'(sif.found), 0);
    check_val({tag, "_err"},    32'(sif.err), 0);
    check_val({tag, "_result"}, 32'(sif.result), 0);
    check_val({tag, "_probes"}, 32'(sif.probes), 0);
  endtask

  // Start (target t) is already set up for the coming edge; follow the search to done.
  task automatic observe(input int t, input bit pulse_busy, input bit chain, input int next_t);
    int c;
    bit seen;
    build_model(t);
    @(posedge clk);
    @(negedge clk);
    sif.start = 1'b0;
    c = 0;
    seen = 1'b0;
    for (int cyc = 0; cyc < W + 4; cyc++) begin
      if (sif.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      check_val($sformatf("t%0d_busy%0d", t, c), 32'(sif.busy), 1);
      check_val($sformatf("t%0d_onehot%0d", t, c),
                32'(one_hot('{equal: c_eq, lower: c_lt, greater: c_gt})), 1);
      if (c < exp_q.size())
        check_val($sformatf("t%0d_guess%0d", t, c), 32'(sif.guess), exp_q[c]);
      c++;
      if (pulse_busy) sif.start = (c == 1);
      @(negedge clk);
    end
    check_val($sformatf("t%0d_done_seen", t), 32'(seen), 1);
    check_val($sformatf("t%0d_probe_cycles", t), c, exp_q.size());
    check_val($sformatf("t%0d_found", t), 32'(sif.found), 1);
    check_val($sformatf("t%0d_err", t), 32'(sif.err), 0);
    check_val($sformatf("t%0d_result", t), 32'(sif.result), t);
    check_val($sformatf("t%0d_probes", t), 32'(sif.probes), exp_q.size());
    check_val($sformatf("t%0d_busy_end", t), 32'(sif.busy), 0);
    check_val($sformatf("t%0d_probes_le", t), 32'(sif.probes <= W + 1), 1);
    if (chain) begin
      target = next_t[W-1:0];
      sif.start = 1'b1;
    end else begin
      sif.start = 1'b0;
      @(negedge clk);
      check_val($sformatf("t%0d_done_pulse", t), 32'(sif.done), 0);
    end
  endtask

  initial begin
    int tmp, j;
    rst = 1'b1;
    sif.start = 1'b0;
    force_zero = 1'b0;
    target = '0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    // Directed targets from the plan.
    target = 4'd11; sif.start = 1'b1; observe(11, 1'b0, 1'b0, 0);
    target = 4'd0;  sif.start = 1'b1; observe(0, 1'b0, 1'b0, 0);
    target = 4'd15; sif.start = 1'b1; observe(15, 1'b0, 1'b0, 0);

    // Flags all low on the first probe.
    force_zero = 1'b1;
    target = 4'd3;
    sif.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sif.start = 1'b0;
    check_val("fz_guess", 32'(sif.guess), 7);
    check_val("fz_busy", 32'(sif.busy), 1);
    @(negedge clk);
    check_val("fz_done", 32'(sif.done), 1);
    check_val("fz_err", 32'(sif.err), 1);
    check_val("fz_found", 32'(sif.found), 0);
    check_val("fz_result", 32'(sif.result), 7);
    check_val("fz_probes", 32'(sif.probes), 1);
    check_val("fz_busy_end", 32'(sif.busy), 0);
    force_zero = 1'b0;
    @(negedge clk);

    // Reset (with simultaneous start) during the third probe of target 0.
    target = 4'd0;
    sif.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sif.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("rst_pre_guess", 32'(sif.guess), 1);
    rst = 1'b1;
    sif.start = 1'b1;
    @(negedge clk);
    check_idle_outputs("midrst");
    rst = 1'b0;
    target = 4'd5;
    observe(5, 1'b0, 1'b0, 0);

    // Randomised-order sweep of all targets, chained through the DONE cycle,
    // with a start pulse while busy on randomly chosen searches.
    for (int i = 0; i < 16; i++) order[i] = i;
    for (int i = 15; i > 0; i--) begin
      j = $urandom_range(i, 0);
      tmp = order[i];
      order[i] = order[j];
      order[j] = tmp;
    end
    target = order[0][W-1:0];
    sif.start = 1'b1;
    for (int i = 0; i < 16; i++) begin
      observe(order[i], 1'($urandom_range(1, 0)), (i < 15), (i < 15) ? order[(i + 1) % 16] : 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
